// File: rtl/sdrc_bank_timer.sv
// sdrc_bank_timer: per-bank SDRAM timing windows and tREFI refresh scheduler.
// Define SDRC_REF_POSTPONE_EN to allow up to 8 postponed refreshes.
module sdrc_bank_timer #(
  parameter int BANKS     = 4,
  parameter int BA_W      = 2,
  parameter int CNT_W     = 5,
  parameter int REF_CNT_W = 16,
  parameter int T_RCD     = 3,
  parameter int T_RAS     = 6,
  parameter int T_RP      = 3,
  parameter int T_RFC     = 10,
  parameter int T_MRD     = 2,
  parameter int T_WR      = 2,
  parameter int BL        = 2,
  parameter int T_REFI    = 1560
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  input  logic [2:0]       cmd,
  input  logic [BA_W-1:0]  cmd_ba,
  output logic [BANKS-1:0] bank_open,
  output logic [BANKS-1:0] act_ok,
  output logic [BANKS-1:0] rw_ok,
  output logic [BANKS-1:0] pre_ok,
  output logic             ref_ok,
  output logic             mrs_ok,
  output logic             ref_req,
  output logic             ref_urgent,
  output logic             cmd_err
);

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_ACT  = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [2:0] C_WR   = 3'd3;
  localparam logic [2:0] C_PRE  = 3'd4;
  localparam logic [2:0] C_PREA = 3'd5;
  localparam logic [2:0] C_REF  = 3'd6;
  localparam logic [2:0] C_MRS  = 3'd7;

`ifdef SDRC_REF_POSTPONE_EN
  localparam int PEND_W = 4;
  localparam int PMAX   = 8;
`else
  localparam int PEND_W = 1;
  localparam int PMAX   = 1;
`endif

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(PMAX);
  localparam logic [CNT_W-1:0] RCD_L = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RAS_L = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] RP_L  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_L = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] MRD_L = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] WR_L  = CNT_W'(BL + T_WR - 1);
  localparam logic [REF_CNT_W-1:0] REFI_L = REF_CNT_W'(T_REFI - 1);

  logic [BANKS-1:0][CNT_W-1:0] act_t;
  logic [BANKS-1:0][CNT_W-1:0] rw_t;
  logic [BANKS-1:0][CNT_W-1:0] pre_t;
  logic [CNT_W-1:0]            g_t;
  logic [REF_CNT_W-1:0]        ref_cnt;
  logic [PEND_W-1:0]           pend;
  logic [CNT_W-1:0]            wr_dec;
  logic [CNT_W-1:0]            wr_pre;
  logic                        g_zero;
  logic                        legal;
  logic                        go;
  logic                        wrap;
  logic                        ref_go;

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  assign g_zero = (g_t == '0);

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      act_ok[b] = !bank_open[b] && (act_t[b] == '0) && g_zero;
      rw_ok[b]  = bank_open[b] && (rw_t[b] == '0);
      pre_ok[b] = (pre_t[b] == '0);
    end
  end

  assign ref_ok     = ~|bank_open && ~|act_t && g_zero;
  assign mrs_ok     = ref_ok;
  assign ref_req    = (pend != '0);
  assign ref_urgent = (pend == PEND_MAX);

  always_comb begin
    legal = 1'b0;
    unique case (cmd)
      C_NOP:       legal = 1'b1;
      C_ACT:       legal = act_ok[cmd_ba];
      C_RD, C_WR:  legal = rw_ok[cmd_ba];
      C_PRE:       legal = pre_ok[cmd_ba];
      C_PREA:      legal = &pre_ok;
      C_REF:       legal = ref_ok;
      C_MRS:       legal = mrs_ok;
      default:     legal = 1'b0;
    endcase
  end

  assign go     = cmd_vld && legal && (cmd != C_NOP);
  assign ref_go = go && (cmd == C_REF);
  assign wrap   = (ref_cnt == REFI_L);
  assign wr_dec = dec(pre_t[cmd_ba]);
  assign wr_pre = (wr_dec > WR_L) ? wr_dec : WR_L;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_open <= '0;
      act_t     <= '0;
      rw_t      <= '0;
      pre_t     <= '0;
      g_t       <= '0;
      ref_cnt   <= '0;
      pend      <= '0;
      cmd_err   <= 1'b0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        act_t[b] <= dec(act_t[b]);
        rw_t[b]  <= dec(rw_t[b]);
        pre_t[b] <= dec(pre_t[b]);
      end
      g_t <= dec(g_t);
      if (go) begin
        unique case (cmd)
          C_ACT: begin
            bank_open[cmd_ba] <= 1'b1;
            rw_t[cmd_ba]      <= RCD_L;
            pre_t[cmd_ba]     <= RAS_L;
          end
          C_WR: pre_t[cmd_ba] <= wr_pre;
          C_PRE: begin
            if (bank_open[cmd_ba]) begin
              bank_open[cmd_ba] <= 1'b0;
              act_t[cmd_ba]     <= RP_L;
            end
          end
          C_PREA: begin
            for (int b = 0; b < BANKS; b++) begin
              if (bank_open[b]) begin
                bank_open[b] <= 1'b0;
                act_t[b]     <= RP_L;
              end
            end
          end
          C_REF: g_t <= RFC_L;
          C_MRS: g_t <= MRD_L;
          default: ;
        endcase
      end
      cmd_err <= cmd_vld && (cmd != C_NOP) && !legal;
      ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
      // A wrap and an accepted REF cancel each other out.
      if (wrap && !ref_go) begin
        if (pend != PEND_MAX) pend <= pend + 1'b1;
      end else if (!wrap && ref_go && (pend != '0)) begin
        pend <= pend - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdrc_bank_timer.sv
// tb_sdrc_bank_timer: directed and random commands against an
// absolute-time reference model of the bank timing rules.
module tb_sdrc_bank_timer;

  localparam int BANKS = 4;
  localparam int BA_W = 2;
  localparam int T_RCD = 3;
  localparam int T_RAS = 6;
  localparam int T_RP = 3;
  localparam int T_RFC = 10;
  localparam int T_MRD = 2;
  localparam int T_WR = 2;
  localparam int BL = 2;
  localparam int T_REFI = 100;
`ifdef SDRC_REF_POSTPONE_EN
  localparam int PMAX = 8;
`else
  localparam int PMAX = 1;
`endif

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] ACT  = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] PRE  = 3'd4;
  localparam logic [2:0] PREA = 3'd5;
  localparam logic [2:0] REF  = 3'd6;
  localparam logic [2:0] MRS  = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_vld = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [BA_W-1:0] cmd_ba = '0;
  logic [BANKS-1:0] bank_open, act_ok, rw_ok, pre_ok;
  logic ref_ok, mrs_ok, ref_req, ref_urgent, cmd_err;

  sdrc_bank_timer #(
    .BANKS(BANKS), .BA_W(BA_W), .CNT_W(5), .REF_CNT_W(16),
    .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP), .T_RFC(T_RFC),
    .T_MRD(T_MRD), .T_WR(T_WR), .BL(BL), .T_REFI(T_REFI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd(cmd),
    .cmd_ba(cmd_ba), .bank_open(bank_open), .act_ok(act_ok),
    .rw_ok(rw_ok), .pre_ok(pre_ok), .ref_ok(ref_ok),
    .mrs_ok(mrs_ok), .ref_req(ref_req), .ref_urgent(ref_urgent),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: each window is the edge number from which the command is legal.
  bit m_open[BANKS];
  int act_rdy[BANKS];
  int rw_rdy[BANKS];
  int pre_rdy[BANKS];
  int g_rdy;
  int pend;
  bit m_err;
  int e;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit x_act(input int b);
    return !m_open[b] && e >= act_rdy[b] && e >= g_rdy;
  endfunction

  function automatic bit x_rw(input int b);
    return m_open[b] && e >= rw_rdy[b];
  endfunction

  function automatic bit x_pre(input int b);
    return e >= pre_rdy[b];
  endfunction

  function automatic bit x_ref();
    bit ok;
    ok = (e >= g_rdy);
    for (int b = 0; b < BANKS; b++)
      if (m_open[b] || e < act_rdy[b]) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit x_prea();
    bit ok;
    ok = 1'b1;
    for (int b = 0; b < BANKS; b++)
      if (!x_pre(b)) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit x_legal(input logic [2:0] c, input int b);
    case (c)
      NOP:     return 1'b1;
      ACT:     return x_act(b);
      RD, WR:  return x_rw(b);
      PRE:     return x_pre(b);
      PREA:    return x_prea();
      default: return x_ref();
    endcase
  endfunction

  function automatic void m_close(input int b);
    if (m_open[b]) begin
      m_open[b] = 1'b0;
      act_rdy[b] = e + T_RP;
    end
  endfunction

  task automatic check_all();
    logic [BANKS-1:0] eo, ea, er, ep;
    for (int b = 0; b < BANKS; b++) begin
      eo[b] = m_open[b];
      ea[b] = x_act(b);
      er[b] = x_rw(b);
      ep[b] = x_pre(b);
    end
    chk("bank_open", 32'(bank_open), 32'(eo));
    chk("act_ok", 32'(act_ok), 32'(ea));
    chk("rw_ok", 32'(rw_ok), 32'(er));
    chk("pre_ok", 32'(pre_ok), 32'(ep));
    chk("ref_ok", 32'(ref_ok), 32'(x_ref()));
    chk("mrs_ok", 32'(mrs_ok), 32'(x_ref()));
    chk("ref_req", 32'(ref_req), 32'(pend != 0));
    chk("ref_urgent", 32'(ref_urgent), 32'(pend == PMAX));
    chk("cmd_err", 32'(cmd_err), 32'(m_err));
  endtask

  task automatic step(input bit v, input logic [2:0] c, input int b);
    bit lg, go, w;
    cmd_vld = v;
    cmd = c;
    cmd_ba = BA_W'(b);
    check_all();
    lg = x_legal(c, b);
    go = v && lg && (c != NOP);
    @(posedge clk);
    #1;
    w = (e % T_REFI) == 0;
    if (go) begin
      case (c)
        ACT: begin
          m_open[b] = 1'b1;
          rw_rdy[b] = e + T_RCD;
          pre_rdy[b] = e + T_RAS;
        end
        WR: if (e + BL + T_WR > pre_rdy[b]) pre_rdy[b] = e + BL + T_WR;
        PRE: m_close(b);
        PREA: for (int i = 0; i < BANKS; i++) m_close(i);
        REF: g_rdy = e + T_RFC;
        MRS: g_rdy = e + T_MRD;
        default: ;
      endcase
    end
    if (w && !(go && c == REF)) pend = (pend < PMAX) ? pend + 1 : PMAX;
    else if (!w && go && c == REF && pend > 0) pend--;
    m_err = v && (c != NOP) && !lg;
    e++;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, NOP, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_vld = 1'b1;
    cmd = 3'($urandom_range(1, 7));
    cmd_ba = BA_W'($urandom_range(0, BANKS - 1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int b = 0; b < BANKS; b++) begin
      m_open[b] = 1'b0;
      act_rdy[b] = 0;
      rw_rdy[b] = 0;
      pre_rdy[b] = 0;
    end
    g_rdy = 0;
    pend = 0;
    m_err = 1'b0;
    e = 1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_open", 32'(bank_open), 32'h0);
    chk("rst_act_ok", 32'(act_ok), 32'hF);
    chk("rst_rw_ok", 32'(rw_ok), 32'h0);
    chk("rst_pre_ok", 32'(pre_ok), 32'hF);
    chk("rst_ref_ok", 32'(ref_ok), 32'h1);
    chk("rst_mrs_ok", 32'(mrs_ok), 32'h1);
    chk("rst_ref_req", 32'(ref_req), 32'h0);
    chk("rst_urgent", 32'(ref_urgent), 32'h0);
    chk("rst_err", 32'(cmd_err), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk_reset_vals();

    // tRCD on bank 0
    step(1'b1, ACT, 0);
    chk("s1_rw_lo", 32'(rw_ok[0]), 32'h0);
    step(1'b1, RD, 0);
    chk("s1_err", 32'(cmd_err), 32'h1);
    chk("s1_open", 32'(bank_open[0]), 32'h1);
    nop(1);
    chk("s1_rw_hi", 32'(rw_ok[0]), 32'h1);
    chk("s1_err_clr", 32'(cmd_err), 32'h0);

    // tRAS then tRP on bank 1
    step(1'b1, ACT, 1);
    nop(2);
    step(1'b1, RD, 1);
    chk("s2_rd", 32'(cmd_err), 32'h0);
    step(1'b1, PRE, 1);
    chk("s2_pre_early", 32'(cmd_err), 32'h1);
    nop(1);
    step(1'b1, PRE, 1);
    chk("s2_pre_ok", 32'(cmd_err), 32'h0);
    chk("s2_closed", 32'(bank_open[1]), 32'h0);
    nop(1);
    step(1'b1, ACT, 1);
    chk("s2_act_early", 32'(cmd_err), 32'h1);
    step(1'b1, ACT, 1);
    chk("s2_act_ok", 32'(cmd_err), 32'h0);
    chk("s2_reopen", 32'(bank_open[1]), 32'h1);

    // write recovery outlasts tRAS on bank 2
    step(1'b1, ACT, 2);
    nop(2);
    step(1'b1, WR, 2);
    nop(2);
    chk("s3_pre_lo", 32'(pre_ok[2]), 32'h0);
    nop(1);
    chk("s3_pre_hi", 32'(pre_ok[2]), 32'h1);
    step(1'b1, PRE, 2);
    chk("s3_pre_err", 32'(cmd_err), 32'h0);
    chk("s3_closed", 32'(bank_open[2]), 32'h0);

    // first refresh request, then REF after PREA
    while (e <= T_REFI) step(1'b0, NOP, 0);
    chk("s4_req", 32'(ref_req), 32'h1);
    step(1'b1, REF, 0);
    chk("s4_ref_open", 32'(cmd_err), 32'h1);
    step(1'b1, PREA, 0);
    chk("s4_prea", 32'(cmd_err), 32'h0);
    nop(2);
    step(1'b1, REF, 0);
    chk("s4_ref", 32'(cmd_err), 32'h0);
    chk("s4_req_clr", 32'(ref_req), 32'h0);
    nop(8);
    chk("s4_act_lo", 32'(act_ok), 32'h0);
    nop(1);
    chk("s4_act_hi", 32'(act_ok), 32'hF);

    // postponement saturation and REF on a wrap edge
    do_reset();
    while (e <= 8 * T_REFI) step(1'b0, NOP, 0);
    chk("s5_urgent", 32'(ref_urgent), 32'h1);
    while (e < 10 * T_REFI) step(1'b0, NOP, 0);
    step(1'b1, REF, 0);
    chk("s5_wrap_req", 32'(ref_req), 32'h1);
    chk("s5_wrap_urg", 32'(ref_urgent), 32'h1);

    // reset in the middle of a tRFC window
    nop(T_RFC);
    step(1'b1, REF, 0);
    chk("s6_ref", 32'(cmd_err), 32'h0);
    nop(3);
    do_reset();
    chk_reset_vals();

    // random traffic with a mid-run reset
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           int'($urandom_range(0, BANKS - 1)));
    end
    check_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
